mem_arbiter: RTL and testbench

//   Two-port arbiter/sequencer in front of the single-port data Memory (64 x 32b, byte base 1024).

---
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter in front of the 64 x 32b data Memory; one access per 3 cycles.
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie (port 1 may then starve).
module mem_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int          DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        win;
  logic [31:0] sel_addr;
  logic [31:0] read_data;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a < END_ADDR) && (a[1:0] == 2'b00);
  endfunction

  always_comb begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    win = p0_req ? 1'b0 : 1'b1;
`else
    win = (p0_req && p1_req) ? ~last_grant_q : (p0_req ? 1'b0 : 1'b1);
`endif
    sel_addr  = win ? p1_addr : p0_addr;
    read_data = (valid_q && !we_q) ? mem_rdata : 32'h0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant_d      = win;
          last_grant_d = win;
          we_d         = win ? p1_we : p0_we;
          addr_d       = sel_addr;
          wdata_d      = win ? p1_wdata : p0_wdata;
          valid_d      = addr_ok(sel_addr);
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Read data lands directly in the winner's output register so it is valid with the ack.
        if (grant_q) p1_rdata_d = read_data;
        else         p0_rdata_d = read_data;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      we_q         <= 1'b0;
      valid_q      <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      p0_rdata_q   <= 32'h0;
      p1_rdata_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
    end
  end

  // Strobes are gated by rst so a reset edge can never commit a Memory write.
  assign mem_read  = rst && (state_q == ACCESS) && valid_q && !we_q;
  assign mem_write = rst && (state_q == ACCESS) && valid_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign p0_ack   = (state_q == RESP) && !grant_q;
  assign p1_ack   = (state_q == RESP) && grant_q;
  assign p0_err   = p0_ack && !valid_q;
  assign p1_err   = p1_ack && !valid_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 64-word Memory, table of single-port transactions,
// plus hand sequences for reset, continuous contention and reset during ACCESS.
module tb_mem_arbiter;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy;
  logic        mem_clear;

  logic [31:0] mem [0:63];
  logic [31:0] exp_rd [2];
  logic        last_grant_m;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs [13];

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on posedge while MemWrite is high.
  assign mem_rdata = (mem_addr >= 32'd1024 && mem_addr < 32'd1280) ? mem[mem_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drivePort(input logic port, input logic req, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (port) begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end else begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end
  endtask

  // One transaction on one port with the other port idle; expects ack two edges after the grant edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    int   k = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;
    logic got = 1'b0;
    drivePort(v.port, 1'b1, v.we, v.addr, v.wdata);
    while (!got && k < 8) begin
      @(posedge clk); #1;
      k++;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (k == 1) checkOutput($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
      if (p0_ack || p1_ack) got = 1'b1;
    end
    checkOutput($sformatf("v%0d_latency", idx), 32'(k), 32'd2);
    checkOutput($sformatf("v%0d_ack", idx), 32'(v.port ? p1_ack : p0_ack), 32'd1);
    checkOutput($sformatf("v%0d_other_ack", idx), 32'(v.port ? p0_ack : p1_ack), 32'd0);
    checkOutput($sformatf("v%0d_err", idx), 32'(v.port ? p1_err : p0_err), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_rdata", idx), v.port ? p1_rdata : p0_rdata, v.exp_rdata);
    checkOutput($sformatf("v%0d_other_rdata", idx), v.port ? p0_rdata : p1_rdata, exp_rd[!v.port]);
    checkOutput($sformatf("v%0d_wr_strobes", idx), 32'(wr_cnt), 32'(!v.exp_err && v.we));
    checkOutput($sformatf("v%0d_rd_strobes", idx), 32'(rd_cnt), 32'(!v.exp_err && !v.we));
    exp_rd[v.port] = v.exp_rdata;
    last_grant_m = v.port;
    drivePort(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput($sformatf("v%0d_idle_after", idx), {30'b0, busy, p0_ack | p1_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    int   k;
    logic w;
    logic lg;
    logic e0, e1;

    vecs[0]  = '{1'b0, 1'b1, 32'd1024,       32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'd1024,       32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'd1020,       32'h0,        1'b1, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'd1280,       32'h0,        1'b1, 32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'd1026,       32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'd1276,       32'h12345678, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 32'd1276,       32'h0,        1'b0, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b0, 32'd1276,       32'h0,        1'b0, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b1, 32'd1028,       32'hA5A50001, 1'b0, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 32'd1028,       32'h0,        1'b0, 32'hA5A50001};
    vecs[10] = '{1'b0, 1'b0, 32'hFFFFFFFC,   32'h0,        1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 32'd1279,       32'hFFFFFFFF, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'd1024,       32'h0,        1'b0, 32'hDEADBEEF};

    // Reset with both ports requesting: everything stays quiet.
    rst = 1'b0;
    mem_clear = 1'b1;
    drivePort(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0);
    drivePort(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0);
    @(posedge clk); #1;
    mem_clear = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_acks", {30'b0, p0_ack, p1_ack}, 32'd0);
    checkOutput("rst_errs", {30'b0, p0_err, p1_err}, 32'd0);
    checkOutput("rst_p0_rdata", p0_rdata, 32'h0);
    checkOutput("rst_p1_rdata", p1_rdata, 32'h0);
    checkOutput("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    // First tie after reset goes to port 0.
    rst = 1'b1;
    k = 0;
    while (!(p0_ack || p1_ack) && k < 8) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("first_tie_latency", 32'(k), 32'd2);
    checkOutput("first_tie_p0_ack", 32'(p0_ack), 32'd1);
    checkOutput("first_tie_p1_ack", 32'(p1_ack), 32'd0);
    checkOutput("first_tie_p0_err", 32'(p0_err), 32'd0);
    drivePort(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drivePort(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    last_grant_m = 1'b0;

    for (int i = 0; i < 13; i++) applyStimulus(vecs[i], i);

    // Continuous contention: one ack every 3 cycles, winners from the arbitration model.
    drivePort(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0);
    drivePort(1'b1, 1'b1, 1'b0, 32'd1276, 32'h0);
    lg = last_grant_m;
    w  = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c % 3 == 1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
        w = 1'b0;
`else
        w = ~lg;
`endif
        lg = w;
      end
      e0 = (c % 3 == 2) && !w;
      e1 = (c % 3 == 2) && w;
      checkOutput($sformatf("contend_c%0d_acks", c), {30'b0, p0_ack, p1_ack}, {30'b0, e0, e1});
      if (e0) checkOutput($sformatf("contend_c%0d_p0_rdata", c), p0_rdata, 32'hDEADBEEF);
      if (e1) checkOutput($sformatf("contend_c%0d_p1_rdata", c), p1_rdata, 32'h12345678);
      if (e0) exp_rd[0] = 32'hDEADBEEF;
      if (e1) exp_rd[1] = 32'h12345678;
      if (c == 11) begin
        drivePort(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drivePort(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    checkOutput("contend_idle", 32'(busy), 32'd0);
    last_grant_m = lg;

    // Reset asserted during ACCESS of a port 0 write: no strobe at the reset edge, no ack.
    drivePort(1'b0, 1'b1, 1'b1, 32'd1032, 32'h0BADF00D);
    @(posedge clk); #1;
    checkOutput("midrst_write_before", 32'(mem_write), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("midrst_write_gated", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_ack", {30'b0, p0_ack, p1_ack}, 32'd0);
    drivePort(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("midrst_quiet_c%0d", c), {29'b0, busy, p0_ack, p1_ack}, 32'd0);
    end
    checkOutput("midrst_mem_word", mem[2], 32'h0);
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    last_grant_m = 1'b1;
    v = '{1'b0, 1'b0, 32'd1032, 32'h0, 1'b0, 32'h0};
    applyStimulus(v, 13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
